// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker: drives every input vector in order, samples after HOLD cycles, compares to EXP.
// Optional capture log of sampled responses is enabled by defining TT_SWEEP_CAPTURE_LOG_EN.
module tt_sweep_checker #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    parameter int HOLD  = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP = 24'hFAC688
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic [N_IN-1:0]  stim_o,
    input  logic [N_OUT-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N_IN:0]    err_count_o,
    output logic [N_OUT-1:0] err_mask_o,
    output logic [N_IN-1:0]  first_err_idx_o,
    output logic             first_err_valid_o,
    input  logic [N_IN-1:0]  rd_addr_i,
    output logic [N_OUT-1:0] rd_data_o
);

    localparam int NVEC = 2**N_IN;
    localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_cnt_q, err_cnt_d;
    logic [N_OUT-1:0] err_mask_q, err_mask_d;
    logic [N_IN-1:0]  fei_q, fei_d;
    logic             fev_q, fev_d;

    logic [N_OUT-1:0] exp_vec;
    logic [N_OUT-1:0] diff;
    logic             sample;

    assign exp_vec = EXP[idx_q*N_OUT +: N_OUT];
    assign diff    = dut_out_i ^ exp_vec;
    assign sample  = (state_q == S_RUN) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        fei_d      = fei_q;
        fev_d      = fev_q;
        case (state_q)
            S_RUN: begin
                if (sample) begin
                    if (diff != '0) begin
                        err_cnt_d  = err_cnt_q + 1'b1;
                        err_mask_d = err_mask_q | diff;
                        if (!fev_q) begin
                            fei_d = idx_q;
                            fev_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        stim_d  = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        stim_d = idx_q + 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE share the restart path; results hold until start.
                if (start_i) begin
                    state_d    = S_RUN;
                    idx_d      = '0;
                    hold_d     = '0;
                    stim_d     = '0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    err_mask_d = '0;
                    fei_d      = '0;
                    fev_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            fei_q      <= '0;
            fev_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            fei_q      <= fei_d;
            fev_q      <= fev_d;
        end
    end

    assign stim_o            = stim_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_cnt_q;
    assign err_mask_o        = err_mask_q;
    assign first_err_idx_o   = fei_q;
    assign first_err_valid_o = fev_q;

`ifdef TT_SWEEP_CAPTURE_LOG_EN
    // Not reset: each sweep overwrites every entry anyway.
    logic [N_OUT-1:0] log_q [NVEC];

    always_ff @(posedge clk_i) begin
        if (sample) log_q[idx_q] <= dut_out_i;
    end

    assign rd_data_o = log_q[rd_addr_i];
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr_i;
    assign rd_data_o      = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: HOLD=1 and HOLD=3 instances, directed and random faulty-device sweeps.
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] and_m = 3'b111, or_m = 3'b000, xr_m = 3'b000;
    logic [2:0] rd_addr = 3'd0;

    logic [2:0] stim_a, stim_b, dout_a, dout_b, mask_a, mask_b, fei_a, fei_b, rd_a, rd_b;
    logic [3:0] ec_a, ec_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    always #5 clk = ~clk;

    // Device model: a 3-bit identity block with configurable stuck/inverted bits.
    assign dout_a = ((stim_a & and_m) | or_m) ^ xr_m;
    assign dout_b = ((stim_b & and_m) | or_m) ^ xr_m;

    tt_sweep_checker #(.N_IN(3), .N_OUT(3), .HOLD(1)) ua (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .stim_o(stim_a), .dut_out_i(dout_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(ec_a), .err_mask_o(mask_a),
        .first_err_idx_o(fei_a), .first_err_valid_o(fev_a), .rd_addr_i(rd_addr), .rd_data_o(rd_a));

    tt_sweep_checker #(.N_IN(3), .N_OUT(3), .HOLD(3)) ub (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .stim_o(stim_b), .dut_out_i(dout_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(ec_b), .err_mask_o(mask_b),
        .first_err_idx_o(fei_b), .first_err_valid_o(fev_b), .rd_addr_i(rd_addr), .rd_data_o(rd_b));

    logic [2:0] m_stim, m_mask, m_fei;
    logic [3:0] m_ec;
    logic       m_busy, m_done, m_pass, m_fev;
    always_comb begin
        m_stim = (sel == 0) ? stim_a : stim_b;
        m_mask = (sel == 0) ? mask_a : mask_b;
        m_fei  = (sel == 0) ? fei_a  : fei_b;
        m_ec   = (sel == 0) ? ec_a   : ec_b;
        m_busy = (sel == 0) ? busy_a : busy_b;
        m_done = (sel == 0) ? done_a : done_b;
        m_pass = (sel == 0) ? pass_a : pass_b;
        m_fev  = (sel == 0) ? fev_a  : fev_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] resp(input int v);
        logic [2:0] x;
        x = 3'(v);
        return ((x & and_m) | or_m) ^ xr_m;
    endfunction

    // Golden table is the identity: vector i should produce i.
    task automatic model(output int ec, output logic [2:0] em, output int fi, output bit fv);
        ec = 0; em = 3'b000; fi = 0; fv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (int'(resp(i)) != i) begin
                ec++;
                em |= resp(i) ^ 3'(i);
                if (!fv) begin fi = i; fv = 1'b1; end
            end
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic check_results(input string tag);
        int ec, fi; logic [2:0] em; bit fv;
        model(ec, em, fi, fv);
        chk({tag, "_err_count"}, m_ec, ec);
        chk({tag, "_err_mask"}, m_mask, em);
        chk({tag, "_first_valid"}, m_fev, fv);
        chk({tag, "_first_idx"}, m_fei, fv ? fi : 0);
        chk({tag, "_pass"}, m_pass, (ec == 0));
    endtask

    task automatic sweep(input string tag, input int hold, input bit keep_start);
        int bc, dc, bad, pr;
        bit seen, fin;
        bc = 0; dc = 0; bad = 0; pr = 0; seen = 1'b0; fin = 1'b0;
        @(negedge clk); set_start(1'b1);
        @(negedge clk); if (!keep_start) set_start(1'b0);
        for (int c = 0; c < 300 && !fin; c++) begin
            if (m_busy) begin
                if (m_stim !== 3'(bc / hold)) bad++;
                if (m_pass) pr++;
                bc++;
                if (keep_start && bc == hold * 8) set_start(1'b0);
            end
            if (m_done) begin dc++; seen = 1'b1; end
            else if (seen) fin = 1'b1;
            if (!fin) @(negedge clk);
        end
        set_start(1'b0);
        chk({tag, "_completed"}, fin, 1);
        chk({tag, "_stim_seq_bad"}, bad, 0);
        chk({tag, "_busy_cycles"}, bc, hold * 8);
        chk({tag, "_done_pulses"}, dc, 1);
        chk({tag, "_pass_in_run"}, pr, 0);
        chk({tag, "_stim_after"}, m_stim, 0);
        check_results(tag);
    endtask

    task automatic check_log(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
`ifdef TT_SWEEP_CAPTURE_LOG_EN
            chk({tag, "_log"}, rd_a, resp(a));
`else
            chk({tag, "_log_off"}, rd_a, 0);
`endif
            chk({tag, "_log_off_b"}, rd_b, (rd_b === 3'bxxx) ? 0 : rd_b);
        end
    endtask

    initial begin
        bit found;
        int dc;
        repeat (2) @(negedge clk);
        chk("rst_stim", {stim_b, stim_a}, 0);
        chk("rst_busy", {busy_b, busy_a}, 0);
        chk("rst_done", {done_b, done_a}, 0);
        chk("rst_pass", {pass_b, pass_a}, 0);
        chk("rst_err_count", {ec_b, ec_a}, 0);
        chk("rst_err_mask", {mask_b, mask_a}, 0);
        chk("rst_first", {fev_b, fei_b, fev_a, fei_a}, 0);
        rst_n = 1'b1;

        sel = 0;
        and_m = 3'b111; or_m = 3'b000; xr_m = 3'b000;
        sweep("loop_a", 1, 1'b0);

        and_m = 3'b110;
        sweep("stuck0_a", 1, 1'b0);
        check_log("stuck0");
        repeat (3) @(negedge clk);
        chk("pass_held_done", pass_a, 0);
        chk("err_held_done", ec_a, 4);

        and_m = 3'b111;
        sweep("restart_held_a", 1, 1'b1);
        sweep("restart_again_a", 1, 1'b0);

        sel = 1;
        sweep("hold3_loop", 3, 1'b0);
        for (int r = 0; r < 2; r++) begin
            and_m = 3'($urandom); or_m = 3'($urandom) & ~and_m; xr_m = 3'($urandom);
            sweep("hold3_rand", 3, 1'b0);
        end

        sel = 0;
        and_m = 3'b110; or_m = 3'b000; xr_m = 3'b000;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (busy_a && stim_a == 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reached", found, 1);
        chk("rst_mid_errs_before", ec_a, 2);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_stim", stim_a, 0);
        chk("rst_mid_err_count", ec_a, 0);
        dc = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a) dc++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", dc, 0);
        sweep("after_rst_a", 1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            and_m = 3'($urandom); or_m = 3'($urandom_range(0, 7)) & ~and_m; xr_m = 3'($urandom);
            sweep("rand_a", 1, 1'b0);
            check_log("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
